// File: rtl/neuron_layer_seq_if.sv
// ----------------------------------------------------------------------------
// neuron_layer_seq_if
// Result stream between the layer sequencer and the next layer's result buffer.
//
// Signals:
//   res_valid  producer -> consumer   result offered
//   res_ready  consumer -> producer   result accepted
//   res_idx    producer -> consumer   neuron index of the offered result
//   res_data   producer -> consumer   offered 8-bit result
//
// Modports:
//   master  sequencer side (drives valid/idx/data)
//   slave   result-buffer side (drives ready)
// ----------------------------------------------------------------------------
interface neuron_layer_seq_if #(
    parameter int ADDR_W = 5
);
    logic              res_valid;
    logic              res_ready;
    logic [ADDR_W-1:0] res_idx;
    logic [7:0]        res_data;

    modport master (
        output res_valid,
        output res_idx,
        output res_data,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_idx,
        input  res_data,
        output res_ready
    );
endinterface

// File: rtl/neuron_layer_seq.sv
// ----------------------------------------------------------------------------
// neuron_layer_seq
// Time-multiplexes one shared combinational neuron datapath across all neurons
// of a layer. A pass latches the four layer inputs and the weight-ROM base
// address, then for each neuron fetches its 35-bit weight word from a
// synchronous ROM, presents it to the neuron, registers the neuron output and
// offers it on the valid/ready result stream.
//
// Optional feature: define LAYER_ARGMAX_EN to build a per-pass argmax tracker
// on max_idx/max_val. Without it those ports are tied to zero.
//
// Parameters:
//   NUM_NEURONS  neurons per layer pass (1..2^ADDR_W)
//   ADDR_W       weight ROM address width
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a pass (honoured only when idle)
//   base_addr           ROM address of neuron 0's weight word
//   in1u..in4u          unsigned layer inputs
//   busy                high whenever a pass is in progress
//   w_addr / w_data     ROM read address (registered) / ROM data (1-cycle latency)
//   n_weight, n_in1..4  operands presented to the neuron
//   n_out               neuron result (combinational from n_weight / n_in*)
//   res                 result stream (master side)
//   done                one-cycle end-of-pass pulse
//   max_idx, max_val    argmax of the pass results (LAYER_ARGMAX_EN only)
// ----------------------------------------------------------------------------
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start
// S_FETCH | w_addr = base+idx is at the ROM
// S_LOAD  | w_data valid, captured into n_weight
// S_EVAL  | n_out settles, captured into res_data
// S_EMIT  | result offered, waiting for res_ready
// S_DONE  | done pulse, return to idle
module neuron_layer_seq #(
    parameter int NUM_NEURONS = 8,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        in1u,
    input  logic [7:0]        in2u,
    input  logic [7:0]        in3u,
    input  logic [7:0]        in4u,
    output logic              busy,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [34:0]       w_data,
    output logic [34:0]       n_weight,
    output logic [7:0]        n_in1,
    output logic [7:0]        n_in2,
    output logic [7:0]        n_in3,
    output logic [7:0]        n_in4,
    input  logic [7:0]        n_out,
    neuron_layer_seq_if.master res,
    output logic              done,
    output logic [ADDR_W-1:0] max_idx,
    output logic [7:0]        max_val
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EVAL,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] base_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            base_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            w_addr       <= '0;
            n_weight     <= '0;
            n_in1        <= '0;
            n_in2        <= '0;
            n_in3        <= '0;
            n_in4        <= '0;
            res.res_valid <= 1'b0;
            res.res_idx   <= '0;
            res.res_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        n_in1  <= in1u;
                        n_in2  <= in2u;
                        n_in3  <= in3u;
                        n_in4  <= in4u;
                        idx    <= '0;
                        w_addr <= base_addr;
                        busy   <= 1'b1;
                        state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    n_weight <= w_data;
                    state    <= S_EVAL;
                end
                S_EVAL: begin
                    res.res_data  <= n_out;
                    res.res_idx   <= idx;
                    res.res_valid <= 1'b1;
                    state         <= S_EMIT;
                end
                S_EMIT: begin
                    if (res.res_ready) begin
                        res.res_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            // done is registered so it is high during S_DONE
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx    <= idx + ADDR_W'(1);
                            // address arithmetic wraps modulo 2^ADDR_W
                            w_addr <= base_q + idx + ADDR_W'(1);
                            state  <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LAYER_ARGMAX_EN
    // Strict greater-than keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_idx <= '0;
            max_val <= '0;
        end else if (state == S_IDLE && start) begin
            max_idx <= '0;
            max_val <= '0;
        end else if (state == S_EVAL && n_out > max_val) begin
            max_idx <= idx;
            max_val <= n_out;
        end
    end
`else
    assign max_idx = '0;
    assign max_val = '0;
`endif

endmodule

// File: tb/tb_neuron_layer_seq.sv
module tb_neuron_layer_seq;
    localparam int N  = 4;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [7:0]    in1u, in2u, in3u, in4u;
    logic          busy;
    logic [AW-1:0] w_addr;
    logic [34:0]   w_data;
    logic [34:0]   n_weight;
    logic [7:0]    n_in1, n_in2, n_in3, n_in4;
    logic [7:0]    n_out;
    logic          done;
    logic [AW-1:0] max_idx;
    logic [7:0]    max_val;

    neuron_layer_seq_if #(.ADDR_W(AW)) res_if ();

    neuron_layer_seq #(.NUM_NEURONS(N), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in1u      (in1u),
        .in2u      (in2u),
        .in3u      (in3u),
        .in4u      (in4u),
        .busy      (busy),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .n_weight  (n_weight),
        .n_in1     (n_in1),
        .n_in2     (n_in2),
        .n_in3     (n_in3),
        .n_in4     (n_in4),
        .n_out     (n_out),
        .res       (res_if.master),
        .done      (done),
        .max_idx   (max_idx),
        .max_val   (max_val)
    );

    always #5 clk = ~clk;

    // Synchronous weight ROM: data valid the cycle after the address.
    logic [34:0] rom [32];
    always @(posedge clk) w_data <= rom[w_addr];

    // Neuron model: word = {w1,w2,w3,w4,b}, 7-bit signed each;
    // out = clamp((sum in_i*w_i + b) >>> 2, 0, 255).
    function automatic logic [7:0] neuron_f(input logic [34:0] w,
                                            input logic [7:0] a, b, c, d);
        logic signed [6:0] w1, w2, w3, w4, bs;
        int acc;
        w1 = w[34:28]; w2 = w[27:21]; w3 = w[20:14]; w4 = w[13:7]; bs = w[6:0];
        acc = int'(a) * int'(w1) + int'(b) * int'(w2) + int'(c) * int'(w3)
            + int'(d) * int'(w4) + int'(bs);
        acc = acc >>> 2;
        if (acc < 0) return 8'd0;
        if (acc > 255) return 8'd255;
        return 8'(acc);
    endfunction

    always_comb n_out = neuron_f(n_weight, n_in1, n_in2, n_in3, n_in4);

    function automatic logic [34:0] mkw(input int w1, input int b);
        logic [6:0] a7, b7;
        a7 = 7'(w1);
        b7 = 7'(b);
        return {a7, 21'd0, b7};
    endfunction

    int vectors = 0;
    int miscompares = 0;
    int cnum;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cnum++;
    endtask

    // Results captured by run_pass
    logic [7:0] r_data [8];
    int         r_idx  [8];
    int         r_cyc  [8];
    int         waddr_s[8];
    int         r_n, done_cyc, done_cnt;
    logic       stall_ok, busy_after, timed_out;
    logic [7:0] mv;
    int         mi;

    task automatic run_pass(input logic [AW-1:0] b, input logic [7:0] a,
                            input int st_idx, input int st_n);
        int stalls;
        logic [7:0] hd;
        int hi;
        logic rec_next;
        r_n = 0; done_cyc = -1; done_cnt = 0; stall_ok = 1'b1; stalls = 0;
        rec_next = 1'b0; timed_out = 1'b0; hd = '0; hi = 0; mv = '0; mi = 0;
        for (int i = 0; i < 8; i++) waddr_s[i] = -1;
        base_addr = b; in1u = a; in2u = 0; in3u = 0; in4u = 0;
        res_if.res_ready = 1'b1;
        start = 1'b1;
        cnum = 0;
        tick();
        start = 1'b0;
        waddr_s[0] = int'(w_addr);
        while (!(done_cyc >= 0 && cnum > done_cyc)) begin
            if (cnum >= 200) begin
                timed_out = 1'b1;
                break;
            end
            if (res_if.res_valid && int'(res_if.res_idx) == st_idx && stalls < st_n) begin
                if (stalls == 0) begin
                    hd = res_if.res_data;
                    hi = int'(res_if.res_idx);
                end
                res_if.res_ready = 1'b0;
                stalls++;
            end else begin
                if (stalls > 0 && res_if.res_valid && int'(res_if.res_idx) == st_idx &&
                    res_if.res_data != hd)
                    stall_ok = 1'b0;
                res_if.res_ready = 1'b1;
            end
            if (stalls > 0 && res_if.res_valid && int'(res_if.res_idx) == st_idx &&
                (res_if.res_data != hd || int'(res_if.res_idx) != hi))
                stall_ok = 1'b0;
            if (res_if.res_valid && res_if.res_ready && r_n < 8) begin
                r_data[r_n] = res_if.res_data;
                r_idx[r_n]  = int'(res_if.res_idx);
                r_cyc[r_n]  = cnum;
                r_n++;
                rec_next = 1'b1;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cnum;
                mv = max_val;
                mi = int'(max_idx);
            end
            tick();
            if (rec_next) begin
                if (r_n < 8) waddr_s[r_n] = int'(w_addr);
                rec_next = 1'b0;
            end
        end
        busy_after = busy;
        res_if.res_ready = 1'b1;
        chk("pass_timeout", {63'd0, timed_out}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = '0;
        for (int k = 0; k < 4; k++) rom[k] = mkw(k + 1, 0);
        rom[8]  = mkw(63, 0);
        rom[9]  = mkw(-1, 0);
        rom[10] = mkw(0, 0);
        rom[11] = mkw(0, 20);
        rom[12] = mkw(5, 0);
        rom[13] = mkw(9, 0);
        rom[14] = mkw(9, 0);
        rom[15] = mkw(3, 0);
        rom[30] = mkw(1, 0);
        rom[31] = mkw(2, 0);

        rst = 1'b1; start = 1'b0; base_addr = '0;
        in1u = 0; in2u = 0; in3u = 0; in4u = 0;
        res_if.res_ready = 1'b1;
        cnum = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", res_if.res_valid, 0);
        chk("rst_data", res_if.res_data, 0);
        chk("rst_idx", res_if.res_idx, 0);
        chk("rst_waddr", w_addr, 0);
        chk("rst_nweight", n_weight, 0);
        chk("rst_nin", {n_in1, n_in2, n_in3, n_in4}, 0);
        chk("rst_max", {max_idx, max_val}, 0);

        // Basic pass: results 2,4,6,8 on cycles 4,8,12,16, done at 17
        run_pass(5'd0, 8'd8, -1, 0);
        chk("A_count", r_n, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("A_data%0d", k), r_data[k], 2 * (k + 1));
            chk($sformatf("A_idx%0d", k), r_idx[k], k);
            chk($sformatf("A_cyc%0d", k), r_cyc[k], 4 + 4 * k);
            chk($sformatf("A_waddr%0d", k), waddr_s[k], k);
        end
        chk("A_done_cyc", done_cyc, 17);
        chk("A_done_cnt", done_cnt, 1);
        chk("A_busy_fall", busy_after, 0);

        // Saturation / clamp / bias
        run_pass(5'd8, 8'd255, -1, 0);
        chk("S_sat", r_data[0], 8'hFF);
        chk("S_clamp", r_data[1], 8'h00);
        chk("S_zero", r_data[2], 8'h00);
        chk("S_bias", r_data[3], 5);

        // Backpressure: 3 stall cycles in idx 1's EMIT
        run_pass(5'd0, 8'd8, 1, 3);
        chk("B_count", r_n, 4);
        chk("B_stable", stall_ok, 1);
        chk("B_cyc1", r_cyc[1], 11);
        chk("B_cyc3", r_cyc[3], 19);
        chk("B_done_cyc", done_cyc, 20);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("B_data%0d", k), r_data[k], 2 * (k + 1));
            chk($sformatf("B_idx%0d", k), r_idx[k], k);
        end

        // Address wrap: 30,31,0,1
        run_pass(5'd30, 8'd8, -1, 0);
        chk("W_waddr0", waddr_s[0], 30);
        chk("W_waddr1", waddr_s[1], 31);
        chk("W_waddr2", waddr_s[2], 0);
        chk("W_waddr3", waddr_s[3], 1);
        chk("W_data", {r_data[0], r_data[1], r_data[2], r_data[3]}, {8'd2, 8'd4, 8'd2, 8'd4});

        // Argmax: results 5,9,9,3
        run_pass(5'd12, 8'd4, -1, 0);
        chk("M_data", {r_data[0], r_data[1], r_data[2], r_data[3]}, {8'd5, 8'd9, 8'd9, 8'd3});
`ifdef LAYER_ARGMAX_EN
        chk("M_max_val", mv, 9);
        chk("M_max_idx", mi, 1);
`else
        chk("M_max_val", mv, 0);
        chk("M_max_idx", mi, 0);
`endif

        // Mid-pass start ignored, reset in EVAL of idx 2
        base_addr = 5'd0; in1u = 8'd8;
        start = 1'b1;
        cnum = 0;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; base_addr = 5'd7; in1u = 8'd99;
        tick();
        start = 1'b0;
        begin
            int dseen;
            dseen = 0;
            while (cnum < 11) begin
                if (done) dseen++;
                if (cnum == 5) begin
                    chk("R_nin1_kept", n_in1, 8);
                    chk("R_waddr_kept", w_addr, 1);
                end
                if (cnum == 8) chk("R_res1", {res_if.res_idx, res_if.res_data}, {5'd1, 8'd4});
                tick();
            end
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("R_busy", busy, 0);
            chk("R_valid", res_if.res_valid, 0);
            chk("R_data", res_if.res_data, 0);
            chk("R_idx", res_if.res_idx, 0);
            chk("R_waddr", w_addr, 0);
            chk("R_nweight", n_weight, 0);
            chk("R_nin", {n_in1, n_in2, n_in3, n_in4}, 0);
            chk("R_max", {max_idx, max_val}, 0);
            while (cnum < 24) begin
                if (done || busy) dseen++;
                tick();
            end
            chk("R_no_done", dseen, 0);
        end

        run_pass(5'd0, 8'd8, -1, 0);
        chk("P_data", {r_data[0], r_data[1], r_data[2], r_data[3]}, {8'd2, 8'd4, 8'd6, 8'd8});
        chk("P_done_cyc", done_cyc, 17);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/neuron_layer_seq.md
# neuron_layer_seq

Sequencer that time-multiplexes one shared `neuron` datapath across all neurons of a network layer. On `start` it latches the four 8-bit layer inputs and a weight-ROM base address. For each neuron index it then:
- fetches the 35-bit packed weight word from a synchronous ROM,
- presents the word and the inputs to the neuron,
- registers the neuron's output and offers it on a valid/ready result port.

It sits between the layer input buffer / weight ROM and the next layer's result buffer in the Morse decoder pipeline.

## Interface
Parameters:
- `NUM_NEURONS`, default 8: neurons evaluated per layer pass; legal range 1..2^ADDR_W.
- `ADDR_W`, default 5: weight ROM address width.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a layer pass; honoured only in IDLE.
- `base_addr`  in  ADDR_W  ROM address of neuron 0's weight word; latched on accepted start.
- `in1u`, `in2u`, `in3u`, `in4u`  in  8 each  layer inputs, unsigned; latched on accepted start.
- `busy`  out  1  high in every state except IDLE.
- `w_addr`  out  ADDR_W  ROM read address, registered.
- `w_data`  in  35  ROM data; valid one cycle after `w_addr` is presented.
- `n_weight`  out  35  weight word to the neuron, registered.
- `n_in1`..`n_in4`  out  8 each  latched inputs to the neuron.
- `n_out`  in  8  neuron result, combinational from `n_weight` / `n_in*`.
- `res_valid`  out  1  result offered.
- `res_ready`  in  1  downstream accepts the result.
- `res_idx`  out  ADDR_W  neuron index of the offered result.
- `res_data`  out  8  offered result, registered.
- `done`  out  1  one-cycle pulse at the end of a pass.
- `max_idx`  out  ADDR_W  argmax index; see Configuration.
- `max_val`  out  8  argmax value; see Configuration.

## Operation
The FSM has five states: IDLE, FETCH, LOAD, EVAL, EMIT, plus DONE.
- **IDLE**
  - On `start`=1: latch `base_addr`, `in*`; idx←0; `w_addr`←`base_addr`; go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH**
  - `w_addr` = base+idx is stable at the ROM this cycle.
  - Go to LOAD.
- **LOAD**
  - `w_data` is valid; `n_weight`←`w_data` at the end of the cycle.
  - Go to EVAL.
- **EVAL**
  - `n_out` settles from `n_weight`.
  - `res_data`←`n_out`, `res_idx`←idx, `res_valid`←1.
  - Go to EMIT.
- **EMIT**
  - Hold `res_valid`, `res_data`, `res_idx` stable until `res_valid`&`res_ready`.
  - On handshake, `res_valid`←0.
  - If idx==NUM_NEURONS-1, go to DONE.
  - Otherwise idx←idx+1, `w_addr`←base+idx+1, go to FETCH.
- **DONE**
  - `done`=1 for exactly this cycle.
  - Go to IDLE.

Arithmetic and width rules:
- `w_addr` = (base + idx) mod 2^ADDR_W; it wraps silently past the top of the ROM.
- idx counts 0..NUM_NEURONS-1 and never exceeds that range.

Boundary conditions:
- `start` while busy: ignored; latched values are unchanged.
- `start` held high: a new pass is accepted on the first IDLE cycle after DONE.
- `res_ready` high before `res_valid`: has no effect; it is sampled only in EMIT.
- `rst` at any point: the FSM returns to IDLE next cycle and the pass is discarded; no partial `done` is issued.
- NUM_NEURONS=1: the pass is FETCH, LOAD, EVAL, EMIT, DONE.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `res_valid`=0.
  - `res_data`=0, `res_idx`=0, `w_addr`=0, `n_weight`=0.
  - `n_in1`..`n_in4`=0, `max_idx`=0, `max_val`=0.
- With `start` sampled high at cycle 0 and `res_ready` tied high:
  - Neuron k's result is valid at cycle 4+4k.
  - `done`=1 at cycle 4·NUM_NEURONS+1.
  - `busy` falls at cycle 4·NUM_NEURONS+2, and the next `start` can be accepted in that cycle.
- Each cycle `res_ready` stays low in EMIT adds one cycle to the pass.
- There is no combinational path from `res_ready` to any output.

## Configuration
- Macro `LAYER_ARGMAX_EN`.
- Defined:
  - Per pass, `max_val`/`max_idx` track the largest `res_data` over the pass; they update in EVAL.
  - The comparison is strictly greater-than, so on a tie the lowest index wins.
  - Trackers clear on an accepted `start`.
  - Final values are valid when `done`=1 and hold until the next `start`.
- Undefined: the ports remain, driven constant 0, and no tracking logic is built.

## Test plan
- Single pass, NUM_NEURONS=4, `base_addr`=0, in1u=8, others 0, ROM word k has w1=k+1, other weights 0, b=0, `res_ready`=1:
  - Results are 2, 4, 6, 8 at idx 0..3 on cycles 4, 8, 12, 16.
  - `done` pulses at cycle 17.
- Saturation and clamp: in1u=255 with w1=63 gives `res_data`=0xFF; w1=-1 gives `res_data`=0x00.
- Backpressure: drop `res_ready` for 3 cycles in idx 1's EMIT:
  - `res_data`/`res_idx` stay stable throughout.
  - `done` moves to cycle 20.
  - No result is dropped or duplicated.
- Address wrap, ADDR_W=5: `base_addr`=30 with NUM_NEURONS=4 gives `w_addr` sequence 30, 31, 0, 1.
- `start` pulsed mid-pass and `rst` asserted in EVAL of idx 2:
  - The mid-pass `start` is ignored.
  - After reset, all outputs are at their reset values, `done` never pulses, and a new pass runs cleanly.
- With `LAYER_ARGMAX_EN`, results 5, 9, 9, 3 give `max_val`=9 and `max_idx`=1 at `done`. Without the macro, both stay 0.
